// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state type and the default frame geometry
// used by the RX sequencer, the TX side and the baud tick generator.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample tick counter for the UART receiver. Emits a strobe at the middle of
// the start bit and one at the end of every full bit period.
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic sample_tick,
  output logic mid_start,
  output logic bit_done
);

  localparam int CW = $clog2(OVERSAMPLE);

  logic [CW-1:0] tick_cnt_q;
  logic [CW-1:0] tick_cnt_d;
  logic          advance;

  assign advance   = enable && sample_tick;
  assign mid_start = advance && (tick_cnt_q == CW'(OVERSAMPLE / 2 - 1));
  assign bit_done  = advance && (tick_cnt_q == CW'(OVERSAMPLE - 1));

  // Counter wraps to zero on the bit-period boundary so it never exceeds OVERSAMPLE-1.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (clear) begin
      tick_cnt_d = '0;
    end else if (advance) begin
      if (tick_cnt_q == CW'(OVERSAMPLE - 1)) begin
        tick_cnt_d = '0;
      end else begin
        tick_cnt_d = tick_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: qualifies the start bit, samples data and stop bits at
// mid-bit, and hands finished bytes to the consumer through a valid/ready register.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rx_in,
  input  logic                 data_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int BW = $clog2(DATA_BITS + 1);

  rx_state_t            state_q, state_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  logic timer_clear;
  logic timer_en;
  logic mid_start;
  logic bit_done;
  logic byte_done;

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (timer_clear),
    .enable     (timer_en),
    .sample_tick(sample_tick),
    .mid_start  (mid_start),
    .bit_done   (bit_done)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = overrun_q;
    timer_clear  = 1'b0;
    timer_en     = 1'b0;
    byte_done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        timer_clear = 1'b1;
        if (sample_tick && !rx_in) begin
          state_d = START;
        end
      end
      START: begin
        timer_en = 1'b1;
        if (mid_start) begin
          if (rx_in) begin
            state_d = IDLE;
          end else begin
            state_d     = DATA;
            timer_clear = 1'b1;
            bit_cnt_d   = '0;
          end
        end
      end
      DATA: begin
        timer_en = 1'b1;
        if (bit_done) begin
          shift_d   = {rx_in, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        timer_en = 1'b1;
        if (bit_done) begin
          if (rx_in) begin
            byte_done = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        timer_clear = 1'b1;
        if (sample_tick && rx_in) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A completion beats a same-cycle consume; a full register keeps its old byte.
    if (byte_done) begin
      if (!data_valid_q || data_ready) begin
        data_out_d   = shift_q;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (data_ready && data_valid_q) begin
      data_valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: a table of whole frames plus directed
// sequences for glitches, breaks, overrun, same-cycle consume and mid-frame reset.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_tick;
  logic       rx_in;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  int         cur_tick;
  int         rises;
  int         fe_cnt;
  int         rise_tick;
  int         fe_tick;
  logic [7:0] rise_byte;
  logic       prev_valid;
  logic       ready_level;

  typedef struct {
    logic [7:0] data;
    logic       ready;
    logic       stop_val;
    int         exp_rises;
    logic [7:0] exp_byte;
    int         exp_fe;
    int         exp_tick;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[5];

  uart_rx_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .sample_tick(sample_tick),
    .rx_in      (rx_in),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic observe();
    if (data_valid && !prev_valid) begin
      rises++;
      rise_tick = cur_tick;
      rise_byte = data_out;
    end
    if (frame_err) begin
      fe_cnt++;
      fe_tick = cur_tick;
    end
    prev_valid = data_valid;
  endtask

  task automatic clearStats();
    rises      = 0;
    fe_cnt     = 0;
    rise_tick  = -1;
    fe_tick    = -1;
    rise_byte  = '0;
    prev_valid = data_valid;
  endtask

  // One oversample tick every four clocks; outputs are observed on falling edges.
  task automatic sendTick(input logic v, input logic rdy_pulse);
    @(negedge clk);
    rx_in       = v;
    sample_tick = 1'b1;
    data_ready  = ready_level | rdy_pulse;
    @(negedge clk);
    sample_tick = 1'b0;
    data_ready  = ready_level;
    observe();
    repeat (2) begin
      @(negedge clk);
      observe();
    end
  endtask

  // Whole frame with tick index 0 at the first low start-bit tick.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_val, input int stop_ticks,
                               input logic rdy_at_stop);
    for (int i = 0; i < 144 + stop_ticks; i++) begin
      logic v;
      cur_tick = i;
      if (i < 16) v = 1'b0;
      else if (i < 144) v = b[(i - 16) / 16];
      else v = stop_val;
      sendTick(v, rdy_at_stop && (i == 152));
    end
  endtask

  task automatic idleTicks(input int n);
    for (int i = 0; i < n; i++) begin
      cur_tick++;
      sendTick(1'b1, 1'b0);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst         = 1'b1;
    rx_in       = 1'b1;
    sample_tick = 1'b0;
    data_ready  = ready_level;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clearStats();
  endtask

  initial begin
    vecs[0] = '{8'h5A, 1'b1, 1'b1, 1, 8'h5A, 0, 152, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1, 8'hA5, 0, 152, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 1, 8'h00, 0, 152, 1'b1};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1, 8'hFF, 0, 152, 1'b0};
    vecs[4] = '{8'h3C, 1'b1, 1'b0, 0, 8'h00, 1, 152, 1'b0};

    rst         = 1'b1;
    rx_in       = 1'b1;
    sample_tick = 1'b0;
    data_ready  = 1'b0;
    ready_level = 1'b0;
    cur_tick    = 0;
    doReset();

    checkOutput("reset_data_out", data_out, 0);
    checkOutput("reset_data_valid", data_valid, 0);
    checkOutput("reset_frame_err", frame_err, 0);
    checkOutput("reset_overrun", overrun, 0);
    checkOutput("reset_busy", busy, 0);

    for (int i = 0; i < 5; i++) begin
      ready_level = vecs[i].ready;
      doReset();
      applyStimulus(vecs[i].data, vecs[i].stop_val, 16, 1'b0);
      idleTicks(4);
      checkOutput($sformatf("vec%0d_rises", i), rises, vecs[i].exp_rises);
      if (vecs[i].exp_rises > 0) begin
        checkOutput($sformatf("vec%0d_byte", i), rise_byte, vecs[i].exp_byte);
      end
      checkOutput($sformatf("vec%0d_frame_err", i), fe_cnt, vecs[i].exp_fe);
      checkOutput($sformatf("vec%0d_tick", i), (vecs[i].exp_rises > 0) ? rise_tick : fe_tick,
                  vecs[i].exp_tick);
      checkOutput($sformatf("vec%0d_valid", i), data_valid, vecs[i].exp_valid);
      checkOutput($sformatf("vec%0d_busy", i), busy, 0);
    end

    // Start-bit glitch: low for four ticks only
    ready_level = 1'b1;
    doReset();
    for (int i = 0; i < 8; i++) begin
      cur_tick = i;
      sendTick(i < 4 ? 1'b0 : 1'b1, 1'b0);
      if (i == 0) checkOutput("glitch_busy_t0", busy, 1);
      if (i == 7) checkOutput("glitch_busy_t7", busy, 1);
    end
    cur_tick = 8;
    sendTick(1'b1, 1'b0);
    checkOutput("glitch_busy_t8", busy, 0);
    idleTicks(20);
    checkOutput("glitch_rises", rises, 0);
    checkOutput("glitch_frame_err", fe_cnt, 0);

    // Break: stop bit held low for 40 ticks
    doReset();
    applyStimulus(8'hFF, 1'b0, 40, 1'b0);
    checkOutput("break_frame_err", fe_cnt, 1);
    checkOutput("break_fe_tick", fe_tick, 152);
    checkOutput("break_rises", rises, 0);
    checkOutput("break_busy_wait", busy, 1);
    idleTicks(1);
    checkOutput("break_busy_release", busy, 0);
    clearStats();
    applyStimulus(8'h01, 1'b1, 16, 1'b0);
    checkOutput("break_next_rises", rises, 1);
    checkOutput("break_next_byte", rise_byte, 8'h01);
    checkOutput("break_next_frame_err", fe_cnt, 0);

    // Overrun: two back-to-back bytes, nobody consuming
    ready_level = 1'b0;
    doReset();
    applyStimulus(8'h11, 1'b1, 16, 1'b0);
    applyStimulus(8'h22, 1'b1, 16, 1'b0);
    idleTicks(2);
    checkOutput("ovr_data_out", data_out, 8'h11);
    checkOutput("ovr_valid", data_valid, 1);
    checkOutput("ovr_overrun", overrun, 1);
    checkOutput("ovr_rises", rises, 1);
    @(negedge clk);
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    checkOutput("ovr_consumed_valid", data_valid, 0);
    idleTicks(10);
    checkOutput("ovr_sticky", overrun, 1);
    doReset();
    checkOutput("ovr_cleared_by_rst", overrun, 0);

    // Consumer accepts in the exact clock the second byte completes
    ready_level = 1'b0;
    doReset();
    applyStimulus(8'h11, 1'b1, 16, 1'b0);
    applyStimulus(8'h22, 1'b1, 16, 1'b1);
    idleTicks(2);
    checkOutput("same_clk_data_out", data_out, 8'h22);
    checkOutput("same_clk_valid", data_valid, 1);
    checkOutput("same_clk_overrun", overrun, 0);

    // Reset in the middle of data bit 3
    ready_level = 1'b0;
    doReset();
    applyStimulus(8'h5A, 1'b1, 16, 1'b0);
    for (int i = 0; i < 70; i++) begin
      cur_tick = i;
      sendTick(i < 16 ? 1'b0 : ((i / 16) % 2 == 1), 1'b0);
    end
    checkOutput("midrst_busy_before", busy, 1);
    checkOutput("midrst_valid_before", data_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_valid", data_valid, 0);
    checkOutput("midrst_data_out", data_out, 0);
    checkOutput("midrst_frame_err", frame_err, 0);
    checkOutput("midrst_overrun", overrun, 0);
    rst         = 1'b0;
    ready_level = 1'b1;
    clearStats();
    idleTicks(4);
    applyStimulus(8'hC3, 1'b1, 16, 1'b0);
    idleTicks(2);
    checkOutput("midrst_next_rises", rises, 1);
    checkOutput("midrst_next_byte", rise_byte, 8'hC3);
    checkOutput("midrst_next_tick", rise_tick, 152);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side sequencer for the lab UART. It takes a synchronized serial line and a 16x oversample tick, and qualifies the start bit at mid-bit. It then walks the data and stop bits, sampling each at mid-bit, and delivers the assembled byte through a valid/ready holding register. It sits between the baud tick generator and the byte consumer (FIFO or display logic), and flags framing and overrun errors.

## Interface
- OVERSAMPLE, 16, sample ticks per bit period; power of two, ≥4
- DATA_BITS, 8, data bits per frame, LSB first
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- sample_tick  in  1  one-clk pulse at OVERSAMPLE x baud rate
- rx_in  in  1  serial line, already 2-FF synchronized; idle high
- data_ready  in  1  consumer accepts data_out this cycle
- data_out  out  DATA_BITS  received byte (holding register)
- data_valid  out  1  data_out holds an unconsumed byte
- frame_err  out  1  one-clk pulse: stop bit sampled low
- overrun  out  1  sticky: completed byte dropped because the holding register was full
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- All sampling and counting advances only on clks where sample_tick=1. rx_in is ignored on other clks.
- IDLE: on a tick with rx_in=0, clear tick_cnt and go to START. That tick is T0.
- START: tick_cnt increments per tick. When it reaches OVERSAMPLE/2 (tick T0+8):
  - rx_in=1 is a false start: go to IDLE with no error.
  - rx_in=0: clear tick_cnt and bit_cnt, go to DATA.
- DATA: on the tick where tick_cnt reaches OVERSAMPLE-1, sample rx_in into shift[DATA_BITS-1] and right-shift, so the byte is assembled LSB first. Clear tick_cnt and increment bit_cnt. After DATA_BITS samples, go to STOP.
- STOP: sample at tick_cnt = OVERSAMPLE-1.
  - rx_in=1: byte complete. Go to IDLE.
  - rx_in=0: pulse frame_err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until a tick with rx_in=1, then go to IDLE. This prevents a break condition from retriggering.
- Holding register, on byte complete:
  - If data_valid=0, or data_ready=1 in the same clk: load data_out and set data_valid.
  - Otherwise: keep the old byte and set overrun.
- data_ready with data_valid=1 and no simultaneous completion clears data_valid. data_ready while data_valid=0 is ignored.
- overrun clears only on rst.
- Counter widths: tick_cnt is $clog2(OVERSAMPLE) bits and never wraps past OVERSAMPLE-1. bit_cnt is $clog2(DATA_BITS+1) bits.

## Timing
- Reset values:
  - Outputs: data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0.
  - Internal: state=IDLE, counters and shift register 0.
- rst mid-frame aborts the frame on the next clk edge. rst has priority over every other event.
- Sample points, relative to T0 (tick counts):
  - Start bit: T0+8.
  - Data bit k (k=0..DATA_BITS-1): T0+8+16(k+1).
  - Stop bit: T0+152.
  - These figures are for the defaults.
- data_valid rises and data_out updates on the clk edge that processes the stop-bit tick. They are visible the clk after that tick.
- frame_err is high for exactly one clk, aligned with the clk where data_valid would have risen.
- busy goes high the clk after T0 and falls the clk after the return to IDLE.
- A new start edge is accepted on the first tick after the return to IDLE. Back-to-back frames need no idle gap beyond the stop bit.

## Structure
- Shared package uart_pkg holds:
  - the state typedef `rx_state_t`
  - constants `UART_OVERSAMPLE=16` and `UART_DATA_BITS=8`, reused by the TX side and the tick generator
- One natural sub-module: `uart_bit_timer`. It holds tick_cnt and emits `mid_start` and `bit_done` strobes under clear/enable from the FSM.
- The FSM, shift register and holding register stay in uart_rx_ctrl.

## Test plan
- Frame 0x5A (line 0,0,1,0,1,1,0,1,0,1), data_ready=1 -> data_valid pulses once with data_out=0x5A, exactly 152 ticks after T0; frame_err=0.
- Glitch: rx_in low for 4 ticks, then high -> FSM returns to IDLE at T0+8, busy drops, no data_valid, no frame_err.
- Frame 0xFF with stop bit held low for 40 ticks -> frame_err pulses once, data_valid stays 0. FSM stays in WAIT_HIGH until rx_in rises, then the next frame 0x01 is received correctly.
- Two frames 0x11 then 0x22 with data_ready=0 -> data_out stays 0x11, data_valid=1, overrun=1 after the second stop bit. Overrun clears only after rst.
- data_ready asserted in the exact clk the second byte completes -> data_out=0x22, data_valid stays 1, overrun=0.
- rst asserted mid-DATA at bit 3 -> all outputs 0 next clk. A following frame 0xC3 is received intact.
